// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between NREQ requesters. A
// round-robin arbiter picks one valid requester per cycle and steers its
// operation onto the ALU. The ALU result, flags and requester index are
// captured in a one-entry response register. That register drains through a
// valid/ready response port. Draining and loading in the same cycle gives a
// throughput of one operation per cycle.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/ready_o      per-requester handshake (ready is one-hot or 0)
//   req_sel_i/op1_i/op2_i    per-requester payload, flattened, index 0 in LSBs
//   alu_sel_o/op1_o/op2_o    operands steered to the shared ALU
//   alu_res_i/zero_i/neg_i   ALU result and flags
//   resp_valid_o/ready_i     response handshake
//   resp_id_o/res_o/zero_o/neg_o  registered response contents
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [2*NREQ-1:0]        req_sel_i,
    input  logic [NREQ*DWIDTH-1:0]   req_op1_i,
    input  logic [NREQ*DWIDTH-1:0]   req_op2_i,
    output logic [1:0]               alu_sel_o,
    output logic [DWIDTH-1:0]        alu_op1_o,
    output logic [DWIDTH-1:0]        alu_op2_o,
    input  logic [DWIDTH-1:0]        alu_res_i,
    input  logic                     alu_zero_i,
    input  logic                     alu_neg_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [IDW-1:0]           resp_id_o,
    output logic [DWIDTH-1:0]        resp_res_o,
    output logic                     resp_zero_o,
    output logic                     resp_neg_o
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic [IDW-1:0]      rr_ptr_r;
    logic [IDW-1:0]      rr_ptr_nxt_s;
    logic [IDW-1:0]      gnt_idx_s;
    logic                gnt_any_s;
    logic                can_accept_s;
    logic                xfer_s;
    logic                resp_valid_s;
    int                  dist_s;
    int                  best_dist_s;

    logic [IDW-1:0]      resp_id_r;
    logic [DWIDTH-1:0]   resp_res_r;
    logic                resp_zero_r;
    logic                resp_neg_r;

    // The response slot can take a new result when it is empty or when it is
    // draining in this same cycle.
    assign can_accept_s = (state_r == ST_EMPTY) || resp_ready_i;
    assign xfer_s       = can_accept_s && gnt_any_s;

    // Round-robin search: pick the valid requester with the smallest
    // circular distance from rr_ptr_r.
    always_comb begin
        gnt_any_s   = |req_valid_i;
        gnt_idx_s   = '0;
        best_dist_s = NREQ;
        dist_s      = 32'sd0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = i - int'(rr_ptr_r);
            if (dist_s < 32'sd0) begin
                dist_s = dist_s + NREQ;
            end else begin
                dist_s = dist_s;
            end
            if (req_valid_i[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                gnt_idx_s   = IDW'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Steer the granted payload to the ALU. The ALU sees ADD 0+0 when nothing
    // is requested. Ready goes only to the granted requester.
    always_comb begin
        alu_sel_o   = 2'b00;
        alu_op1_o   = '0;
        alu_op2_o   = '0;
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any_s && (gnt_idx_s == IDW'(i))) begin
                alu_sel_o      = req_sel_i[2*i +: 2];
                alu_op1_o      = req_op1_i[DWIDTH*i +: DWIDTH];
                alu_op2_o      = req_op2_i[DWIDTH*i +: DWIDTH];
                req_ready_o[i] = can_accept_s;
            end else begin
                req_ready_o[i] = 1'b0;
            end
        end
    end

    // The pointer moves past the granted requester only on an actual transfer.
    // A stalled requester therefore keeps its priority position.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        if (xfer_s) begin
            if (gnt_idx_s == IDW'(NREQ - 1)) begin
                rr_ptr_nxt_s = '0;
            end else begin
                rr_ptr_nxt_s = gnt_idx_s + IDW'(1);
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // FSM state register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_EMPTY;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // FSM next-state logic: a load always leaves the slot FULL; a drain
    // without a load empties it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_nxt_s = ST_FULL;
                end else if (resp_ready_i) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // FSM output decode. This depends only on the state register, so
    // resp_valid_o has no combinational path from resp_ready_i.
    always_comb begin
        resp_valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: resp_valid_s = 1'b0;
            ST_FULL:  resp_valid_s = 1'b1;
            default:  resp_valid_s = 1'b0;
        endcase
    end

    // Response data register. It loads on a transfer and otherwise holds,
    // including after a drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_id_r   <= '0;
            resp_res_r  <= '0;
            resp_zero_r <= 1'b0;
            resp_neg_r  <= 1'b0;
        end else if (xfer_s) begin
            resp_id_r   <= gnt_idx_s;
            resp_res_r  <= alu_res_i;
            resp_zero_r <= alu_zero_i;
            resp_neg_r  <= alu_neg_i;
        end else begin
            resp_id_r   <= resp_id_r;
            resp_res_r  <= resp_res_r;
            resp_zero_r <= resp_zero_r;
            resp_neg_r  <= resp_neg_r;
        end
    end

    assign resp_valid_o = resp_valid_s;
    assign resp_id_o    = resp_id_r;
    assign resp_res_o   = resp_res_r;
    assign resp_zero_o  = resp_zero_r;
    assign resp_neg_o   = resp_neg_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter (NREQ=4, DWIDTH=8) together with a behavioural stand-in
// for the shared ALU. A small reference model of the arbitration predicts
// each grant and pushes the expected response into a queue. The entry is
// popped and compared when the response register is loaded.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    logic                  clk;
    logic                  rst_ni;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_sel;
    logic [NREQ*DW-1:0]    req_op1;
    logic [NREQ*DW-1:0]    req_op2;
    logic [1:0]            alu_sel;
    logic [DW-1:0]         alu_op1;
    logic [DW-1:0]         alu_op2;
    logic [DW-1:0]         alu_res;
    logic                  alu_zero;
    logic                  alu_neg;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [DW-1:0]         resp_res;
    logic                  resp_zero;
    logic                  resp_neg;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  res;
        logic           zero;
        logic           neg;
    } resp_t;

    resp_t sb_q[$];
    resp_t m_last;
    logic  m_full;
    int    m_rr;
    int    n_cmp;
    int    n_bad;

    alu_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .IDW(IDW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_sel_i    (req_sel),
        .req_op1_i    (req_op1),
        .req_op2_i    (req_op2),
        .alu_sel_o    (alu_sel),
        .alu_op1_o    (alu_op1),
        .alu_op2_o    (alu_op2),
        .alu_res_i    (alu_res),
        .alu_zero_i   (alu_zero),
        .alu_neg_i    (alu_neg),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_res_o   (resp_res),
        .resp_zero_o  (resp_zero),
        .resp_neg_o   (resp_neg)
    );

    function automatic logic [DW-1:0] alu_ref(input logic [1:0] s, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    // Behavioural shared ALU
    always_comb alu_res = alu_ref(alu_sel, alu_op1, alu_op2);
    assign alu_zero = (alu_res == 8'h00);
    assign alu_neg  = alu_res[DW-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] s, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        req_valid[i]         = 1'b1;
        req_sel[2*i +: 2]    = s;
        req_op1[DW*i +: DW]  = a;
        req_op2[DW*i +: DW]  = b;
    endtask

    // One clock cycle. Inputs are already driven, and we are just after a
    // rising edge. Checks grant and steering, predicts the response, and
    // checks the response register after the edge.
    task automatic step(input bit drop);
        int              g;
        bit              xf;
        logic [NREQ-1:0] exp_rdy;
        logic [1:0]      s;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        resp_t           e;
        s = 2'b00;
        a = '0;
        b = '0;
        #1;
        g  = model_grant(req_valid, m_rr);
        xf = (g >= 0) && (!m_full || resp_ready);
        exp_rdy = xf ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            s = req_sel[2*g +: 2];
            a = req_op1[DW*g +: DW];
            b = req_op2[DW*g +: DW];
            chk("alu_sel", 32'(alu_sel), 32'(s));
            chk("alu_op1", 32'(alu_op1), 32'(a));
            chk("alu_op2", 32'(alu_op2), 32'(b));
        end else begin
            chk("alu_idle", 32'({alu_sel, alu_op1, alu_op2}), 32'h0);
        end
        if (xf) begin
            e.id   = IDW'(g);
            e.res  = alu_ref(s, a, b);
            e.zero = (e.res == 8'h00);
            e.neg  = e.res[DW-1];
            sb_q.push_back(e);
            m_rr   = (g + 1) % NREQ;
            m_full = 1'b1;
        end else if (m_full && resp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        if (xf) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                m_last = sb_q.pop_front();
            end
            if (drop) req_valid[g] = 1'b0;
        end
        chk("resp_id", 32'(resp_id), 32'(m_last.id));
        chk("resp_res", 32'(resp_res), 32'(m_last.res));
        chk("resp_zero", 32'(resp_zero), 32'(m_last.zero));
        chk("resp_neg", 32'(resp_neg), 32'(m_last.neg));
    endtask

    // Asserts reset between clock edges and checks that outputs clear
    // without a rising edge. Then it releases reset and resyncs to just
    // after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_res", 32'(resp_res), 32'd0);
        chk("rst_flags", 32'({resp_zero, resp_neg}), 32'd0);
        m_full = 1'b0;
        m_rr   = 0;
        m_last = '0;
        sb_q.delete();
        req_valid = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_alu", 32'({alu_sel, alu_op1, alu_op2}), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_ni     = 1'b1;
        req_valid  = '0;
        req_sel    = '0;
        req_op1    = '0;
        req_op2    = '0;
        resp_ready = 1'b0;
        m_full     = 1'b0;
        m_rr       = 0;
        m_last     = '0;

        do_reset();

        // Single request: requester 2, SUB 5-7
        resp_ready = 1'b1;
        set_req(2, OP_SUB, 8'd5, 8'd7);
        step(1'b1);
        chk("single_res", 32'(resp_res), 32'hFE);
        chk("single_id", 32'(resp_id), 32'd2);
        chk("single_flags", 32'({resp_zero, resp_neg}), 32'b01);
        step(1'b1);

        // Fairness: all requesters hold ADD i+i
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 8'(i), 8'(i));
        for (int k = 0; k < 8; k++) begin
            step(1'b0);
            chk("fair_id", 32'(resp_id), 32'(k % NREQ));
            chk("fair_res", 32'(resp_res), 32'(2 * (k % NREQ)));
        end
        req_valid = '0;

        // Backpressure: response FULL, requesters 1 and 3 wait
        resp_ready = 1'b0;
        set_req(1, OP_ADD, 8'h10, 8'h01);
        set_req(3, OP_SUB, 8'h03, 8'h09);
        for (int k = 0; k < 5; k++) step(1'b1);
        chk("bp_hold_id", 32'(resp_id), 32'd3);
        chk("bp_hold_res", 32'(resp_res), 32'd6);
        resp_ready = 1'b1;
        step(1'b1);
        chk("bp_id1", 32'(resp_id), 32'd1);
        chk("bp_res1", 32'(resp_res), 32'h11);
        step(1'b1);
        chk("bp_id3", 32'(resp_id), 32'd3);
        chk("bp_res3", 32'(resp_res), 32'hFA);
        step(1'b1);

        // Zero flag and op coverage
        set_req(0, OP_OR, 8'h00, 8'h00);
        step(1'b1);
        chk("or_zero", 32'({resp_res, resp_zero, resp_neg}), 32'({8'h00, 1'b1, 1'b0}));
        set_req(0, OP_AND, 8'hF0, 8'h0F);
        step(1'b1);
        chk("and_zero", 32'({resp_res, resp_zero}), 32'({8'h00, 1'b1}));
        set_req(0, OP_ADD, 8'hFF, 8'h01);
        step(1'b1);
        chk("add_wrap", 32'({resp_res, resp_zero}), 32'({8'h00, 1'b1}));
        step(1'b1);

        // Pointer hold under backpressure
        do_reset();
        resp_ready = 1'b1;
        set_req(3, OP_ADD, 8'd1, 8'd1);
        step(1'b1);
        chk("ph_id3", 32'(resp_id), 32'd3);
        resp_ready = 1'b0;
        set_req(0, OP_ADD, 8'd2, 8'd2);
        step(1'b1);
        step(1'b1);
        resp_ready = 1'b1;
        step(1'b1);
        chk("ph_id0", 32'(resp_id), 32'd0);
        set_req(0, OP_ADD, 8'd5, 8'd5);
        set_req(1, OP_ADD, 8'd6, 8'd6);
        step(1'b1);
        chk("ph_ptr1", 32'(resp_id), 32'd1);
        step(1'b1);
        chk("ph_next0", 32'(resp_id), 32'd0);
        step(1'b1);

        // Reset while a response is held
        set_req(2, OP_AND, 8'hFF, 8'h3C);
        step(1'b1);
        chk("rm_id2", 32'(resp_id), 32'd2);
        resp_ready = 1'b0;
        step(1'b1);
        do_reset();
        resp_ready = 1'b1;
        set_req(1, OP_ADD, 8'd7, 8'd8);
        set_req(2, OP_SUB, 8'd1, 8'd2);
        step(1'b1);
        chk("rm_first1", 32'(resp_id), 32'd1);
        step(1'b1);
        chk("rm_then2", 32'(resp_id), 32'd2);
        step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
